signal_gen_dds: RTL and testbench
=================================

Name: signal_gen_dds

Overview:
Parametrised direct-digital-synthesis core; successor to the fixed-rate sine address counter in the signal generator toplevel.
- A PHASE_W phase accumulator, stepped by a runtime tuning word, drives the external sine ROM.
- Also generates sawtooth, triangle and square directly from phase.
- Tuning word is adjusted by debounced faster/slower pulses, with saturation.
- Sits between the key edge detectors (sw_up/sw_down) and the DAC GPIO output.

Parameters:
- PHASE_W, 24, accumulator width; must be >= DATA_W+1 and >= ADDR_W.
- ADDR_W, 10, sine ROM address width.
- DATA_W, 16, sample width, unsigned offset binary (midscale = 2^(DATA_W-1)).
- ROM_LAT, 1, ROM read latency in cycles (legal 1 or 2).
- FTW_DEFAULT, 256, tuning word after reset.
- FTW_STEP, 16, increment/decrement per faster/slower pulse.
- FTW_MIN, 16, lower saturation bound (> 0).
- FTW_MAX, 2^(PHASE_W-1), upper saturation bound.

Ports:
- clk50m, in, 1, system clock.
- rst_n, in, 1, asynchronous active-low reset.
- en, in, 1, accumulator advances while high.
- phase_clr, in, 1, synchronous phase clear pulse.
- faster, in, 1, single-cycle pulse: ftw += FTW_STEP.
- slower, in, 1, single-cycle pulse: ftw -= FTW_STEP.
- mode, in, 2, 0 sine, 1 sawtooth, 2 triangle, 3 square.
- rom_addr, out, ADDR_W, sine ROM address.
- rom_data, in, DATA_W, sine ROM data.
- wave_out, out, DATA_W, output sample.
- wave_valid, out, 1, wave_out corresponds to an enabled phase step.
- ftw_out, out, PHASE_W, current tuning word.
- at_min, out, 1, ftw == FTW_MIN.
- at_max, out, 1, ftw == FTW_MAX.
- wrap, out, 1, one-cycle pulse on accumulator overflow (one period).

Behaviour:
- Reset (async, rst_n low): phase = 0, ftw = FTW_DEFAULT, rom_addr = 0, wave_out = 0, wave_valid = 0, wrap = 0, all pipeline registers = 0. at_min/at_max are combinational from ftw.
- Tuning word, updated on the clock edge after the pulse:
  - faster only: ftw = min(ftw+FTW_STEP, FTW_MAX).
  - slower only: ftw = max(ftw-FTW_STEP, FTW_MIN).
  - Both in the same cycle, or neither: unchanged.
  - Sums are computed one bit wider, so there is no wrap-around before clamping.
- Accumulator:
  - phase_clr has priority: phase = 0, wrap = 0.
  - Else if en: phase = (phase + ftw) mod 2^PHASE_W; wrap = carry-out.
  - Else: hold, wrap = 0.
  - A ftw change takes effect from the next accumulation.
- Stage 1 (registered):
  - rom_addr = phase[PHASE_W-1 -: ADDR_W].
  - mode and en captured.
  - Direct waveforms computed from p = phase[PHASE_W-2 -: DATA_W]:
    - saw = phase[PHASE_W-1 -: DATA_W].
    - tri = phase[PHASE_W-1] ? ~p : p.
    - sq = phase[PHASE_W-1] ? all ones : 0.
- Delay: direct waveforms, mode and en are delayed ROM_LAT cycles to align with rom_data.
- Output register: wave_out = aligned mode==0 ? rom_data : selected direct value; wave_valid = aligned en.
- Latency: sample for phase value P at cycle t appears on wave_out at t+1+ROM_LAT, constant for all modes.
- Mode change mid-stream: no phase reset. The first new-mode sample appears 1+ROM_LAT cycles after the change, with no glitch sample mixing modes.
- en deassert: phase freezes; pipeline drains; wave_out holds its last value; wave_valid falls 1+ROM_LAT cycles later.
- Reset mid-operation: all state returns to reset values immediately; ftw reverts to FTW_DEFAULT.

Optional Feature:
SIGNAL_GEN_DDS_AMPLITUDE_EN
- Enabled: adds input amp_shift [2:0]. The output register computes wave_out = mid + ((x - mid) >>> amp_shift), where x is the selected sample and the signed difference is DATA_W+1 bits. amp_shift is sampled at stage 1 and delayed with mode. Latency is unchanged.
- Disabled: no port; wave_out = x.

Test Plan:
- Reset, then release with en=0 -> ftw_out=256, wave_out=0, wave_valid=0, at_min=at_max=0, wrap=0.
- 20 faster pulses, 3 idle cycles apart -> ftw_out=576. Then 40 slower pulses -> ftw_out saturates at 16, at_min=1, no underflow.
- faster and slower asserted in the same cycle at ftw=576 -> ftw_out stays 576.
- mode=1, en=1, ftw=2^14 (PHASE_W=24) -> wrap pulses every 1024 cycles.
  - wave_out ramps by 2^14·2^16/2^24 = 64 per sample, 0 to 65472 then back to 0.
  - wave_valid rises 2 cycles after en (ROM_LAT=1).
- mode=3 then mode=2 at ftw=2^14:
  - Square: 512 samples of 0x0000 then 512 of 0xFFFF.
  - Triangle: peak 0xFFFF at phase 0x7FFFFF, 0x0000 at phase 0.
  - Mode switch: new waveform exactly 2 cycles later, phase continuous.
- mode=0 with sine ROM loaded, ftw=2^14 -> rom_addr steps by 1 each cycle.
  - wave_out equals ROM word at rom_addr from 1 cycle earlier.
  - Assert rst_n low mid-period -> all outputs 0 and ftw_out=256 immediately.

Source files
------------

// File: rtl/signal_gen_dds.sv
// signal_gen_dds: direct-digital-synthesis core. A runtime tuning word steps a
// phase accumulator that addresses an external sine ROM and also yields
// sawtooth, triangle and square samples directly from phase.
// Optional feature macro: SIGNAL_GEN_DDS_AMPLITUDE_EN (adds amp_shift scaling).
// ROM_LAT counts the rom_addr register as the ROM's first latency cycle, so
// ROM_LAT-1 extra delay stages sit between stage 1 and the output register.
module signal_gen_dds #(
  parameter int unsigned PHASE_W     = 24,
  parameter int unsigned ADDR_W      = 10,
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned ROM_LAT     = 1,
  parameter int unsigned FTW_DEFAULT = 256,
  parameter int unsigned FTW_STEP    = 16,
  parameter int unsigned FTW_MIN     = 16,
  parameter int unsigned FTW_MAX     = 2 ** (PHASE_W - 1)
) (
  input  logic               clk50m,
  input  logic               rst_n,
  input  logic               en,
  input  logic               phase_clr,
  input  logic               faster,
  input  logic               slower,
  input  logic [1:0]         mode,
`ifdef SIGNAL_GEN_DDS_AMPLITUDE_EN
  input  logic [2:0]         amp_shift,
`endif
  output logic [ADDR_W-1:0]  rom_addr,
  input  logic [DATA_W-1:0]  rom_data,
  output logic [DATA_W-1:0]  wave_out,
  output logic               wave_valid,
  output logic [PHASE_W-1:0] ftw_out,
  output logic               at_min,
  output logic               at_max,
  output logic               wrap
);

  localparam int unsigned     EW       = PHASE_W + 1;
  localparam logic [EW-1:0]   STEP_E   = EW'(FTW_STEP);
  localparam logic [EW-1:0]   MAX_E    = EW'(FTW_MAX);
  localparam logic [EW-1:0]   DN_LIMIT = EW'(FTW_MIN + FTW_STEP);
`ifdef SIGNAL_GEN_DDS_AMPLITUDE_EN
  localparam logic [DATA_W-1:0] MID    = {1'b1, {(DATA_W-1){1'b0}}};
`endif

  logic [PHASE_W-1:0] phase;
  logic [PHASE_W-1:0] ftw_nxt;
  logic [EW-1:0]      ftw_up;
  logic [EW-1:0]      acc_sum;
  logic [DATA_W-1:0]  p_c;
  logic [DATA_W-1:0]  dir_c;

  logic [1:0]         s1_mode;
  logic               s1_en;
  logic [DATA_W-1:0]  s1_dir;
  logic [1:0]         al_mode;
  logic               al_en;
  logic [DATA_W-1:0]  al_dir;
  logic [DATA_W-1:0]  x_c;
  logic [DATA_W-1:0]  y_c;
`ifdef SIGNAL_GEN_DDS_AMPLITUDE_EN
  logic [2:0]         s1_amp;
  logic [2:0]         al_amp;
  logic signed [DATA_W:0] diff_c;
  logic signed [DATA_W:0] scaled_c;
`endif

  assign at_min = (ftw_out == PHASE_W'(FTW_MIN));
  assign at_max = (ftw_out == PHASE_W'(FTW_MAX));

  // Saturating tuning-word update; the sum is one bit wider so it cannot wrap
  always_comb begin
    ftw_up  = {1'b0, ftw_out} + STEP_E;
    ftw_nxt = ftw_out;
    if (faster && !slower) begin
      ftw_nxt = (ftw_up > MAX_E) ? PHASE_W'(FTW_MAX) : ftw_up[PHASE_W-1:0];
    end else if (slower && !faster) begin
      ftw_nxt = ({1'b0, ftw_out} < DN_LIMIT) ? PHASE_W'(FTW_MIN)
                                             : ftw_out - PHASE_W'(FTW_STEP);
    end
  end

  assign acc_sum = {1'b0, phase} + {1'b0, ftw_out};

  // Tuning word and phase accumulator; carry-out marks one output period
  always_ff @(posedge clk50m or negedge rst_n) begin
    if (!rst_n) begin
      ftw_out <= PHASE_W'(FTW_DEFAULT);
      phase   <= '0;
      wrap    <= 1'b0;
    end else begin
      ftw_out <= ftw_nxt;
      if (phase_clr) begin
        phase <= '0;
        wrap  <= 1'b0;
      end else if (en) begin
        phase <= acc_sum[PHASE_W-1:0];
        wrap  <= acc_sum[PHASE_W];
      end else begin
        wrap  <= 1'b0;
      end
    end
  end

  // Direct waveforms derived from the current phase
  always_comb begin
    p_c = phase[PHASE_W-2 -: DATA_W];
    unique case (mode)
      2'd1:    dir_c = phase[PHASE_W-1 -: DATA_W];
      2'd2:    dir_c = phase[PHASE_W-1] ? ~p_c : p_c;
      2'd3:    dir_c = {DATA_W{phase[PHASE_W-1]}};
      default: dir_c = '0;
    endcase
  end

  // Stage 1: ROM address plus the side-band that must travel with it
  always_ff @(posedge clk50m or negedge rst_n) begin
    if (!rst_n) begin
      rom_addr <= '0;
      s1_mode  <= '0;
      s1_en    <= 1'b0;
      s1_dir   <= '0;
`ifdef SIGNAL_GEN_DDS_AMPLITUDE_EN
      s1_amp   <= '0;
`endif
    end else begin
      rom_addr <= phase[PHASE_W-1 -: ADDR_W];
      s1_mode  <= mode;
      s1_en    <= en;
      s1_dir   <= dir_c;
`ifdef SIGNAL_GEN_DDS_AMPLITUDE_EN
      s1_amp   <= amp_shift;
`endif
    end
  end

  generate
    if (ROM_LAT > 1) begin : g_delay
      // Extra stage matching the ROM's registered output
      always_ff @(posedge clk50m or negedge rst_n) begin
        if (!rst_n) begin
          al_mode <= '0;
          al_en   <= 1'b0;
          al_dir  <= '0;
`ifdef SIGNAL_GEN_DDS_AMPLITUDE_EN
          al_amp  <= '0;
`endif
        end else begin
          al_mode <= s1_mode;
          al_en   <= s1_en;
          al_dir  <= s1_dir;
`ifdef SIGNAL_GEN_DDS_AMPLITUDE_EN
          al_amp  <= s1_amp;
`endif
        end
      end
    end else begin : g_nodelay
      // ROM data already aligned with stage 1
      always_comb begin
        al_mode = s1_mode;
        al_en   = s1_en;
        al_dir  = s1_dir;
`ifdef SIGNAL_GEN_DDS_AMPLITUDE_EN
        al_amp  = s1_amp;
`endif
      end
    end
  endgenerate

  // Sample selection (and optional amplitude scaling about midscale)
  always_comb begin
    x_c = (al_mode == 2'd0) ? rom_data : al_dir;
`ifdef SIGNAL_GEN_DDS_AMPLITUDE_EN
    diff_c   = $signed({1'b0, x_c}) - $signed({1'b0, MID});
    scaled_c = diff_c >>> al_amp;
    y_c      = DATA_W'(scaled_c + $signed({1'b0, MID}));
`else
    y_c      = x_c;
`endif
  end

  // Output register: holds the last sample while the pipeline is idle
  always_ff @(posedge clk50m or negedge rst_n) begin
    if (!rst_n) begin
      wave_out   <= '0;
      wave_valid <= 1'b0;
    end else begin
      if (al_en) begin
        wave_out <= y_c;
      end
      wave_valid <= al_en;
    end
  end

endmodule

// File: tb/tb_signal_gen_dds.sv
// Bench for signal_gen_dds: two instances (ROM_LAT=1 default, ROM_LAT=2 with a
// low FTW_MAX) driven by shared inputs, checked against a cycle model.
module tb_signal_gen_dds;

  localparam int unsigned FULL = 32'd1 << 24;
  localparam int unsigned HALF = 32'd1 << 23;

  logic        clk50m = 1'b0;
  logic        rst_n, en, phase_clr, faster, slower;
  logic [1:0]  mode;
  logic [9:0]  rom_addr0, rom_addr1;
  logic [15:0] rom_data0, rom_data1, wave0, wave1;
  logic        valid0, valid1, min0, min1, max0, max1, wrap0, wrap1;
  logic [23:0] ftw0, ftw1;
  logic [15:0] rom [0:1023];
`ifdef SIGNAL_GEN_DDS_AMPLITUDE_EN
  logic [2:0]  amp_shift = 3'd0;
`endif

  always #10 clk50m = ~clk50m;

  assign rom_data0 = rom[rom_addr0];
  always @(posedge clk50m) rom_data1 <= rom[rom_addr1];

  signal_gen_dds u_dut0 (
    .clk50m(clk50m), .rst_n(rst_n), .en(en), .phase_clr(phase_clr),
    .faster(faster), .slower(slower), .mode(mode),
`ifdef SIGNAL_GEN_DDS_AMPLITUDE_EN
    .amp_shift(amp_shift),
`endif
    .rom_addr(rom_addr0), .rom_data(rom_data0), .wave_out(wave0),
    .wave_valid(valid0), .ftw_out(ftw0), .at_min(min0), .at_max(max0),
    .wrap(wrap0)
  );

  signal_gen_dds #(.ROM_LAT(2), .FTW_MAX(1024)) u_dut1 (
    .clk50m(clk50m), .rst_n(rst_n), .en(en), .phase_clr(phase_clr),
    .faster(faster), .slower(slower), .mode(mode),
`ifdef SIGNAL_GEN_DDS_AMPLITUDE_EN
    .amp_shift(amp_shift),
`endif
    .rom_addr(rom_addr1), .rom_data(rom_data1), .wave_out(wave1),
    .wave_valid(valid1), .ftw_out(ftw1), .at_min(min1), .at_max(max1),
    .wrap(wrap1)
  );

  typedef struct { int unsigned val; bit en; } samp_t;
  typedef struct { bit f; bit s; int unsigned ftw0; int unsigned ftw1; } vec_t;

  samp_t       pipe0[$], pipe1[$];
  vec_t        tbl[$];
  int unsigned m_phase [2], m_ftw [2], m_max [2], m_addr [2], exp_wave [2];
  bit          m_wrap [2], exp_valid [2];
  int          n_vec = 0, n_err = 0;

  task automatic check(input string name, input int unsigned act, input int unsigned exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // Sample the spec assigns to a phase value in a given mode
  function automatic int unsigned wave_of(input int unsigned ph, input logic [1:0] md);
    int unsigned a;
    case (md)
      2'd0: begin a = ph >> 14; return 32'(rom[a]); end
      2'd1: return ph >> 8;
      2'd2: return (ph < HALF) ? ((ph >> 7) & 32'hFFFF) : ((FULL - 1 - ph) >> 7);
      default: return (ph >= HALF) ? 32'hFFFF : 32'd0;
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_phase[i] = 0; m_ftw[i] = 256; m_wrap[i] = 0; m_addr[i] = 0;
      exp_wave[i] = 0; exp_valid[i] = 0;
    end
    pipe0.delete();
    pipe1.delete();
  endtask

  task automatic check_all();
    check("ftw0", 32'(ftw0), m_ftw[0]);
    check("ftw1", 32'(ftw1), m_ftw[1]);
    check("at_min0", 32'(min0), 32'(m_ftw[0] == 16));
    check("at_min1", 32'(min1), 32'(m_ftw[1] == 16));
    check("at_max0", 32'(max0), 32'(m_ftw[0] == m_max[0]));
    check("at_max1", 32'(max1), 32'(m_ftw[1] == m_max[1]));
    check("wrap0", 32'(wrap0), 32'(m_wrap[0]));
    check("wrap1", 32'(wrap1), 32'(m_wrap[1]));
    check("rom_addr0", 32'(rom_addr0), m_addr[0]);
    check("rom_addr1", 32'(rom_addr1), m_addr[1]);
    check("wave_out0", 32'(wave0), exp_wave[0]);
    check("wave_out1", 32'(wave1), exp_wave[1]);
    check("wave_valid0", 32'(valid0), 32'(exp_valid[0]));
    check("wave_valid1", 32'(valid1), 32'(exp_valid[1]));
  endtask

  // One clock: snapshot inputs, advance the model, compare everything
  task automatic tick();
    samp_t s;
    bit f, sl, clr, e;
    logic [1:0] md;
    int t;
    f = faster; sl = slower; clr = phase_clr; e = en; md = mode;
    for (int i = 0; i < 2; i++) begin
      s.val = wave_of(m_phase[i], md);
      s.en  = e;
      if (i == 0) pipe0.push_back(s); else pipe1.push_back(s);
      m_addr[i] = m_phase[i] >> 14;
    end
    @(posedge clk50m);
    #1;
    if (pipe0.size() == 2) begin
      s = pipe0.pop_front();
      if (s.en) exp_wave[0] = s.val;
      exp_valid[0] = s.en;
    end
    if (pipe1.size() == 3) begin
      s = pipe1.pop_front();
      if (s.en) exp_wave[1] = s.val;
      exp_valid[1] = s.en;
    end
    for (int i = 0; i < 2; i++) begin
      if (clr) begin
        m_phase[i] = 0; m_wrap[i] = 0;
      end else if (e) begin
        m_wrap[i]  = (m_phase[i] + m_ftw[i]) >= FULL;
        m_phase[i] = (m_phase[i] + m_ftw[i]) % FULL;
      end else begin
        m_wrap[i] = 0;
      end
      if (f && !sl) begin
        m_ftw[i] = (m_ftw[i] + 16 > m_max[i]) ? m_max[i] : m_ftw[i] + 16;
      end else if (sl && !f) begin
        t = int'(m_ftw[i]) - 16;
        m_ftw[i] = (t < 16) ? 16 : 32'(t);
      end
    end
    check_all();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned a, b, prev, mx, mn, nz, no, nw, lastw;
    logic [9:0] paddr;
    rst_n = 0; en = 0; phase_clr = 0; faster = 0; slower = 0; mode = 2'd0;
    for (int i = 0; i < 1024; i++)
      rom[i] = 16'($rtoi(32767.0 + 32767.0 * $sin(6.283185307 * i / 1024.0)));
    m_max[0] = HALF; m_max[1] = 1024;
    model_reset();
    repeat (3) @(posedge clk50m);
    #1 rst_n = 1;
    check_all();
    check("reset_ftw", 32'(ftw0), 256);
    check("reset_wave", 32'(wave0), 0);

    // Tuning-word table: 20 faster, both, 40 faster, 80 slower
    a = 256; b = 256;
    for (int k = 0; k < 141; k++) begin
      vec_t v;
      v.f = (k <= 60);
      v.s = (k == 20) || (k > 60);
      if (v.f && !v.s) begin
        a = (a + 16 > HALF) ? HALF : a + 16;
        b = (b + 16 > 1024) ? 1024 : b + 16;
      end else if (v.s && !v.f) begin
        a = (a < 32) ? 16 : a - 16;
        b = (b < 32) ? 16 : b - 16;
      end
      v.ftw0 = a; v.ftw1 = b;
      tbl.push_back(v);
    end
    foreach (tbl[k]) begin
      faster = tbl[k].f; slower = tbl[k].s;
      tick();
      faster = 0; slower = 0;
      check("tbl_ftw0", 32'(ftw0), tbl[k].ftw0);
      check("tbl_ftw1", 32'(ftw1), tbl[k].ftw1);
      check("tbl_min0", 32'(min0), 32'(tbl[k].ftw0 == 16));
      check("tbl_max1", 32'(max1), 32'(tbl[k].ftw1 == 1024));
      if (k == 19) check("ftw_576", 32'(ftw0), 576);
      if (k == 20) check("ftw_both_576", 32'(ftw0), 576);
      repeat (3) tick();
    end
    check("ftw_floor", 32'(ftw0), 16);

    // Climb to 2^14 with back-to-back pulses
    faster = 1;
    repeat (1023) tick();
    faster = 0;
    check("ftw_2p14", 32'(ftw0), 16384);

    // Sawtooth: valid latency, ramp step, wrap period
    phase_clr = 1; tick(); phase_clr = 0;
    mode = 2'd1; en = 1;
    tick();
    check("valid_lat_c1", 32'(valid0), 0);
    tick();
    check("valid_lat_c2", 32'(valid0), 1);
    check("saw_first", 32'(wave0), 0);
    prev = 32'(wave0); mx = 0; nw = 0; lastw = 0;
    for (int i = 0; i < 2100; i++) begin
      tick();
      check("saw_step", (32'(wave0) - prev) & 32'hFFFF, 64);
      prev = 32'(wave0);
      if (prev > mx) mx = prev;
      if (wrap0) begin
        if (nw > 0) check("wrap_period", 32'(i) - lastw, 1024);
        nw++; lastw = 32'(i);
      end
    end
    check("wrap_count", nw, 2);
    check("saw_max", mx, 65472);

    // Switch to square: old mode for one more sample, new mode exactly after two
    mode = 2'd3;
    tick();
    check("switch_hold_old", 32'(wave0), (prev + 64) & 32'hFFFF);
    tick();
    check("switch_new", 32'(wave0 == 16'h0000 || wave0 == 16'hFFFF), 1);
    nz = 0; no = 0;
    for (int i = 0; i < 1024; i++) begin
      tick();
      if (wave0 == 16'h0000) nz++;
      if (wave0 == 16'hFFFF) no++;
    end
    check("square_zeros", nz, 512);
    check("square_ones", no, 512);

    // Triangle over one full period
    mode = 2'd2;
    repeat (2) tick();
    mx = 0; mn = 32'hFFFF;
    for (int i = 0; i < 1024; i++) begin
      tick();
      if (32'(wave0) > mx) mx = 32'(wave0);
      if (32'(wave0) < mn) mn = 32'(wave0);
    end
    check("tri_peak", mx, 32'hFFFF);
    check("tri_floor", mn, 0);

    // Sine: address steps by one, output is the ROM word one cycle behind
    mode = 2'd0;
    repeat (2) tick();
    paddr = rom_addr0;
    for (int i = 0; i < 700; i++) begin
      tick();
      check("sine_addr_step", 32'(rom_addr0), 32'(10'(paddr + 10'd1)));
      check("sine_data", 32'(wave0), 32'(rom[paddr]));
      paddr = rom_addr0;
    end

    // Asynchronous reset mid-period
    #3 rst_n = 0;
    #1;
    model_reset();
    check_all();
    @(posedge clk50m);
    #1 rst_n = 1;
    check_all();

    // Randomized traffic against the model
    for (int k = 0; k < 3000; k++) begin
      en = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 49) == 0) mode = 2'($urandom_range(0, 3));
      phase_clr = ($urandom_range(0, 99) == 0);
      faster = ($urandom_range(0, 3) == 0);
      slower = ($urandom_range(0, 7) == 0);
      tick();
    end
    en = 0; phase_clr = 0; faster = 0; slower = 0;
    repeat (4) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
